// File: rtl/rv32e_pkg.sv
// Shared RV32E execute-stage definitions: opcodes, ALU function codes, FSM states, default sizes.
package rv32e_pkg;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_NUM_REGS = 16;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] FUNC_ADD  = 3'b000;
  localparam logic [2:0] FUNC_SLL  = 3'b001;
  localparam logic [2:0] FUNC_SLT  = 3'b010;
  localparam logic [2:0] FUNC_SLTU = 3'b011;
  localparam logic [2:0] FUNC_XOR  = 3'b100;
  localparam logic [2:0] FUNC_SR   = 3'b101;
  localparam logic [2:0] FUNC_OR   = 3'b110;
  localparam logic [2:0] FUNC_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPER = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } exec_state_t;

endpackage

// File: rtl/exec_unit_if.sv
// Fetch-side handshake, retire outputs and debug read port of the execute stage.
interface exec_unit_if #(parameter int XLEN = rv32e_pkg::DEF_XLEN);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            done;
  logic [XLEN-1:0] result;
  logic            illegal;
  logic [3:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport master (
    output in_valid, instr, dbg_addr,
    input  in_ready, done, result, illegal, dbg_data
  );

  modport slave (
    input  in_valid, instr, dbg_addr,
    output in_ready, done, result, illegal, dbg_data
  );
endinterface

// File: rtl/alu.sv
// Combinational RV32 integer ALU; f7_bit selects SUB for ADD and arithmetic shift for SR.
module alu
  import rv32e_pkg::*;
#(
  parameter int size = DEF_XLEN
) (
  input  logic [2:0]      func_type,
  input  logic            f7_bit,
  input  logic [size-1:0] value1,
  input  logic [size-1:0] value2,
  output logic [size-1:0] out
);

  localparam int SHW = $clog2(size);

  logic [SHW-1:0] shamt;
  assign shamt = value2[SHW-1:0];

  always_comb begin
    out = '0;
    case (func_type)
      FUNC_ADD:  out = f7_bit ? value1 - value2 : value1 + value2;
      FUNC_SLL:  out = value1 << shamt;
      FUNC_SLT:  out = {{(size-1){1'b0}}, $signed(value1) < $signed(value2)};
      FUNC_SLTU: out = {{(size-1){1'b0}}, value1 < value2};
      FUNC_XOR:  out = value1 ^ value2;
      FUNC_SR:   out = f7_bit ? $unsigned($signed(value1) >>> shamt) : value1 >> shamt;
      FUNC_OR:   out = value1 | value2;
      FUNC_AND:  out = value1 & value2;
      default:   out = '0;
    endcase
  end

endmodule

// File: rtl/rv32e_regfile.sv
// Register file: two async operand reads plus a debug read, one synchronous write, async clear.
// x0 is never written and always reads zero.
module rv32e_regfile
  import rv32e_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] dbg_data,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/exec_unit.sv
// RV32E OP/OP-IMM execute stage: IDLE->OPER->EXEC->WB, done pulses in WB, regfile written leaving WB.
// Accepts one instruction per 4 cycles; in_ready only in IDLE, in_valid while busy is ignored.
// EXEC_ILLEGAL_CHECK_EN enables illegal-encoding detection and write suppression.
module exec_unit
  import rv32e_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input logic         clk,
  input logic         rst_n,
  exec_unit_if.slave  bus
);

  localparam int AW = $clog2(NUM_REGS);

  exec_state_t     state;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] op1_q, op2_q, result_q;
  logic [2:0]      func_q;
  logic            f7_q;
  logic [AW-1:0]   rd_q;
  logic            wr_en_q, done_q, illegal_q;

  logic [XLEN-1:0] rs1_data, rs2_data, alu_out, imm_sext;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            is_op, is_imm, f7_dec, illegal_dec;

  assign opcode   = instr_q[6:0];
  assign f3       = instr_q[14:12];
  assign is_op    = (opcode == OP);
  assign is_imm   = (opcode == OP_IMM);
  assign imm_sext = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  // Only immediate shifts carry the SRA select; ADDI with bit 30 set must still add.
  assign f7_dec   = is_op ? instr_q[30] : (is_imm && f3 == FUNC_SR) ? instr_q[30] : 1'b0;

`ifdef EXEC_ILLEGAL_CHECK_EN
  logic [6:0] f7;
  logic       f7_bad, imm_shift_bad;
  assign f7            = instr_q[31:25];
  assign f7_bad        = (f7 != F7_BASE) && (f7 != F7_ALT);
  assign imm_shift_bad = (f3 == FUNC_SLL || f3 == FUNC_SR) &&
                         (f7_bad || (f7 == F7_ALT && f3 == FUNC_SLL));
  assign illegal_dec   = !(is_op || is_imm) || instr_q[11] || instr_q[19] ||
                         (is_op && (instr_q[24] || f7_bad ||
                                    (f7 == F7_ALT && f3 != FUNC_ADD && f3 != FUNC_SR))) ||
                         (is_imm && imm_shift_bad);
`else
  logic unused_idx_msb;
  assign unused_idx_msb = instr_q[11] ^ instr_q[19];
  assign illegal_dec    = 1'b0;
`endif

  rv32e_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (instr_q[15 +: AW]),
    .rs2_addr (instr_q[20 +: AW]),
    .dbg_addr (bus.dbg_addr[AW-1:0]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_data (bus.dbg_data),
    .we       (state == S_WB && wr_en_q),
    .waddr    (rd_q),
    .wdata    (result_q)
  );

  alu #(.size(XLEN)) u_alu (
    .func_type (func_q),
    .f7_bit    (f7_q),
    .value1    (op1_q),
    .value2    (op2_q),
    .out       (alu_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      instr_q   <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      func_q    <= '0;
      f7_q      <= 1'b0;
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            instr_q <= bus.instr;
            state   <= S_OPER;
          end
        end
        S_OPER: begin
          op1_q     <= rs1_data;
          op2_q     <= is_op ? rs2_data : imm_sext;
          func_q    <= f3;
          f7_q      <= f7_dec;
          rd_q      <= instr_q[7 +: AW];
          wr_en_q   <= (is_op || is_imm) && (instr_q[7 +: AW] != '0) && !illegal_dec;
          illegal_q <= illegal_dec;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= alu_out;
          done_q   <= 1'b1;
          state    <= S_WB;
        end
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state == S_IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: table of single instructions plus held-valid and mid-instruction reset sequences.
module tb_exec_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exec_unit_if #(.XLEN(32)) bus ();

  exec_unit #(.XLEN(32), .NUM_REGS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef EXEC_ILLEGAL_CHECK_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        chk_res;
    logic [31:0] exp_res;
    logic        exp_ill;
    logic [3:0]  reg_idx;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [31:0] instr, input logic chk_res,
                         input logic [31:0] exp_res, input logic exp_ill,
                         input logic [3:0] reg_idx, input logic [31:0] exp_reg);
    vec_t v;
    v.name = name; v.instr = instr; v.chk_res = chk_res; v.exp_res = exp_res;
    v.exp_ill = exp_ill; v.reg_idx = reg_idx; v.exp_reg = exp_reg;
    vq.push_back(v);
  endtask

  // Issue at a negedge while idle; observes the four following negedges (OPER, EXEC, WB, IDLE).
  task automatic run_instr(input logic [31:0] ins, output logic [31:0] res, output logic ill,
                           output int done_at, output int pulses);
    int waited = 0;
    res = '0; ill = 1'b0; done_at = 0; pulses = 0;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready before issue", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.in_valid = 1'b0;
      if (bus.done) begin
        pulses++;
        if (done_at == 0) begin
          done_at = k;
          res     = bus.result;
          ill     = bus.illegal;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic        ill;
    int          done_at, pulses, cnt;
    int          pos [3];

    bus.in_valid = 1'b0;
    bus.instr    = '0;
    bus.dbg_addr = '0;
    rst_n        = 1'b0;

    add_vec("addi x1,x0,5",     32'h00500093, 1'b1, 32'd5,         1'b0,   4'd1,  32'd5);
    add_vec("addi x2,x0,-3",    32'hFFD00113, 1'b1, 32'hFFFFFFFD,  1'b0,   4'd2,  32'hFFFFFFFD);
    add_vec("sub x3,x1,x2",     32'h402081B3, 1'b1, 32'd8,         1'b0,   4'd3,  32'd8);
    add_vec("slt x4,x2,x1",     32'h00112233, 1'b1, 32'd1,         1'b0,   4'd4,  32'd1);
    add_vec("sltu x5,x2,x1",    32'h001132B3, 1'b1, 32'd0,         1'b0,   4'd5,  32'd0);
    add_vec("addi x6,x0,-1",    32'hFFF00313, 1'b1, 32'hFFFFFFFF,  1'b0,   4'd6,  32'hFFFFFFFF);
    add_vec("slli x6,x6,31",    32'h01F31313, 1'b1, 32'h80000000,  1'b0,   4'd6,  32'h80000000);
    add_vec("srai x7,x6,4",     32'h40435393, 1'b1, 32'hF8000000,  1'b0,   4'd7,  32'hF8000000);
    add_vec("srli x8,x6,4",     32'h00435413, 1'b1, 32'h08000000,  1'b0,   4'd8,  32'h08000000);
    add_vec("or x10,x1,x2",     32'h0020E533, 1'b1, 32'hFFFFFFFD,  1'b0,   4'd10, 32'hFFFFFFFD);
    add_vec("addi x11,x1,1024", 32'h40008593, 1'b1, 32'h00000405,  1'b0,   4'd11, 32'h00000405);
    add_vec("addi x0,x0,7",     32'h00700013, 1'b1, 32'd7,         1'b0,   4'd0,  32'd0);
    add_vec("add x16,x1,x1",    32'h00108833, 1'b1, 32'd10,        ILL_EN, 4'd0,  32'd0);
    add_vec("lb x1 no write",   32'h00500083, 1'b0, 32'd0,         ILL_EN, 4'd1,  32'd5);

    repeat (3) @(negedge clk);
    check("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("reset done",     {31'b0, bus.done},     32'd0);
    check("reset result",   bus.result,            32'd0);
    check("reset illegal",  {31'b0, bus.illegal},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.dbg_addr = 4'd15;
    #1 check("reset x15", bus.dbg_data, 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      run_instr(vq[i].instr, res, ill, done_at, pulses);
      check({vq[i].name, " done cycle"}, done_at, 32'd3);
      check({vq[i].name, " done pulses"}, pulses, 32'd1);
      if (vq[i].chk_res) check({vq[i].name, " result"}, res, vq[i].exp_res);
      check({vq[i].name, " illegal"}, {31'b0, ill}, {31'b0, vq[i].exp_ill});
      bus.dbg_addr = vq[i].reg_idx;
      #1 check({vq[i].name, " reg"}, bus.dbg_data, vq[i].exp_reg);
    end
    bus.dbg_addr = 4'd1;
    #1 check("x1 after aliased/illegal writes", bus.dbg_data, 32'd5);

    // in_valid held high across busy cycles: exactly one accept per 4 cycles.
    cnt = 0;
    pos[0] = 0; pos[1] = 0; pos[2] = 0;
    bus.instr    = 32'h00700013;
    bus.in_valid = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if (bus.done) begin
        if (cnt < 3) pos[cnt] = t;
        cnt++;
      end
    end
    bus.in_valid = 1'b0;
    check("held done count", cnt, 32'd3);
    check("held done 1st",   pos[0], 32'd3);
    check("held done 2nd",   pos[1], 32'd7);
    check("held done 3rd",   pos[2], 32'd11);
    check("held result",     bus.result, 32'd7);
    bus.dbg_addr = 4'd0;
    #1 check("held x0", bus.dbg_data, 32'd0);

    // Reset asserted while addi x9,x0,9 is in EXEC.
    @(negedge clk);
    bus.instr    = 32'h00900493;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid-reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("mid-reset done",     {31'b0, bus.done},     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check("post-reset done pulses", cnt, 32'd0);
    check("post-reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("post-reset result",   bus.result, 32'd0);
    bus.dbg_addr = 4'd9;
    #1 check("post-reset x9", bus.dbg_data, 32'd0);
    bus.dbg_addr = 4'd1;
    #1 check("post-reset x1", bus.dbg_data, 32'd0);

    run_instr(32'h00900493, res, ill, done_at, pulses);
    check("addi x9 after reset done cycle", done_at, 32'd3);
    bus.dbg_addr = 4'd9;
    #1 check("addi x9 after reset reg", bus.dbg_data, 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
